// File: rtl/mem_access_unit.sv
// Load/store initiator: turns MIPS lb/lbu/lh/lhu/lw/sb/sh/sw into word accesses, with read-modify-write for sub-word stores.
// Optional misaligned-access trapping is enabled by defining MAU_MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  store,
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state_reg;
  logic        store_reg;
  logic [2:0]  op_reg;
  logic [1:0]  lane_reg;
  logic [15:0] wdata_reg;

  logic        misalign;
  logic [3:0]  lane_en;
  logic [31:0] merged_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_word;

`ifdef MAU_MISALIGN_TRAP_EN
  assign misalign = ((op[1:0] == 2'b01) && addr[0]) || (op[1] && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Byte lanes of the captured word that the sub-word store replaces.
  always_comb begin
    lane_en = 4'b1111;
    case (op_reg[1:0])
      2'b00:   lane_en = 4'b0001 << lane_reg;
      2'b01:   lane_en = lane_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] =
          !lane_en[gi] ? mem_rdata[8*gi +: 8] :
          (op_reg[0] ? wdata_reg[8*(gi%2) +: 8] : wdata_reg[7:0]);
    end
  endgenerate

  always_comb begin
    load_byte = mem_rdata[{lane_reg, 3'b000} +: 8];
    load_half = mem_rdata[{lane_reg[1], 4'b0000} +: 16];
    load_word = mem_rdata;
    case (op_reg[1:0])
      2'b00:   load_word = op_reg[2] ? {24'h0, load_byte} : {{24{load_byte[7]}}, load_byte};
      2'b01:   load_word = op_reg[2] ? {16'h0, load_half} : {{16{load_half[15]}}, load_half};
      default: load_word = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      store_reg <= 1'b0;
      op_reg    <= 3'b000;
      lane_reg  <= 2'b00;
      wdata_reg <= 16'h0;
      ready     <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_write <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      mem_write <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            store_reg <= store;
            op_reg    <= op;
            lane_reg  <= addr[1:0];
            wdata_reg <= wdata[15:0];
            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
            ready     <= 1'b0;
            if (misalign) begin
              state_reg <= RESP;
              done      <= 1'b1;
              err       <= 1'b1;
            end else if (store && op[1]) begin
              // Full-word store needs no read; write straight away.
              state_reg <= WR;
              mem_wdata <= wdata;
              mem_write <= 1'b1;
            end else begin
              state_reg <= RD;
            end
          end
        end
        RD: begin
          if (store_reg) begin
            state_reg <= WR;
            mem_wdata <= merged_word;
            mem_write <= 1'b1;
          end else begin
            state_reg <= RESP;
            rdata     <= load_word;
            done      <= 1'b1;
          end
        end
        WR: begin
          state_reg <= RESP;
          done      <= 1'b1;
        end
        RESP: begin
          state_reg <= IDLE;
          ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random loads/stores against a byte-level memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        store;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready, done, err, mem_write;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  logic        preload;
  logic [31:0] mem [0:63];
  logic [7:0]  rmem [0:255];
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req(req), .store(store), .op(op), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'hA1B2C3D4;
    return (i * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory as little-endian bytes, accesses from the ISA rules.
  function automatic logic [31:0] ref_word(input logic [7:0] a);
    int b;
    b = int'(a) & 252;
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] o, input logic [7:0] a);
`ifdef MAU_MISALIGN_TRAP_EN
    if (o[1:0] == 2'b01) return a[0];
    if (o[1]) return (a[1:0] != 2'b00);
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] o, input logic [7:0] a);
    int b;
    logic [7:0]  v8;
    logic [15:0] v16;
    if (o[1:0] == 2'b00) begin
      v8 = rmem[a];
      return o[2] ? {24'h0, v8} : {{24{v8[7]}}, v8};
    end else if (o[1:0] == 2'b01) begin
      b = int'(a) & 254;
      v16 = {rmem[b+1], rmem[b]};
      return o[2] ? {16'h0, v16} : {{16{v16[15]}}, v16};
    end
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [2:0] o, input logic [7:0] a, input logic [31:0] wd);
    int b;
    if (o[1:0] == 2'b00) begin
      rmem[a] = wd[7:0];
    end else if (o[1:0] == 2'b01) begin
      b = int'(a) & 254;
      rmem[b]   = wd[7:0];
      rmem[b+1] = wd[15:8];
    end else begin
      b = int'(a) & 252;
      for (int k = 0; k < 4; k++) rmem[b+k] = wd[8*k +: 8];
    end
  endtask

  task automatic run_op(input logic st, input logic [2:0] o, input logic [7:0] a, input logic [31:0] wd);
    logic        mis;
    int          exp_done_cyc, exp_wr_cyc;
    int          done_cyc, wr_cyc, wr_count;
    logic        got_err;
    logic [31:0] got_rdata, wr_data, wr_addr;
    mis = ref_misaligned(o, a);
    exp_done_cyc = mis ? 1 : (!st ? 2 : (o[1] ? 2 : 3));
    exp_wr_cyc   = (mis || !st) ? 0 : (o[1] ? 1 : 2);
    if (!mis && !st) exp_rdata = ref_load(o, a);
    if (!mis && st) ref_store(o, a, wd);
    done_cyc = 0; wr_cyc = 0; wr_count = 0;
    got_err = 1'b0; got_rdata = 32'h0; wr_data = 32'h0; wr_addr = 32'h0;

    @(negedge clk);
    check_eq("ready_before", {31'h0, ready}, 32'h1);
    req = 1'b1; store = st; op = o; addr = {24'h0, a}; wdata = wd;
    @(posedge clk);
    #1 req = 1'b0;
    for (int c = 1; c <= 6 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (mem_write) begin
        wr_count++; wr_cyc = c; wr_data = mem_wdata; wr_addr = mem_addr;
      end
      if (done) begin
        done_cyc = c; got_err = err; got_rdata = rdata;
      end
    end
    check_eq("done_cycle", done_cyc, exp_done_cyc);
    check_eq("err", {31'h0, got_err}, {31'h0, mis});
    check_eq("rdata", got_rdata, exp_rdata);
    check_eq("write_cycle", wr_cyc, exp_wr_cyc);
    check_eq("write_count", wr_count, (exp_wr_cyc != 0) ? 1 : 0);
    if (exp_wr_cyc != 0) begin
      check_eq("write_addr", wr_addr, {24'h0, a & 8'hFC});
      check_eq("write_data", wr_data, ref_word(a));
    end
    @(negedge clk);
    check_eq("ready_after", {31'h0, ready}, 32'h1);
    check_eq("mem_word", mem[a[7:2]], ref_word(a));
    $display("txn st=%0d op=%0d addr=%h wdata=%h done@T+%0d err=%0d rdata=%h",
             st, o, a, wd, done_cyc, got_err, got_rdata);
  endtask

  task automatic reset_mid;
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    req = 1'b1; store = 1'b1; op = 3'b000; addr = 32'h40; wdata = 32'h77;
    @(posedge clk);
    #1 req = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("rst_mid_ready", {31'h0, ready}, 32'h1);
    check_eq("rst_mid_done", {31'h0, done}, 32'h0);
    check_eq("rst_mid_err", {31'h0, err}, 32'h0);
    check_eq("rst_mid_mem_write", {31'h0, mem_write}, 32'h0);
    check_eq("rst_mid_rdata", rdata, 32'h0);
    check_eq("rst_mid_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mid_mem_wdata", mem_wdata, 32'h0);
    exp_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || mem_write) done_seen++;
    end
    check_eq("rst_mid_no_done", done_seen, 0);
    check_eq("rst_mid_mem_word", mem[16], ref_word(8'h40));
    $display("txn reset during sb 0x40 rmw: ready=%0d mem[40]=%h", ready, mem[16]);
  endtask

  initial begin
    logic [2:0] ro;
    logic [7:0] ra;
    logic       rs;
    reset = 1'b1; preload = 1'b1; req = 1'b0; store = 1'b0; op = 3'b0;
    addr = 32'h0; wdata = 32'h0; exp_rdata = 32'h0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) rmem[4*i+k] = init_word(i) >> (8*k);
    #1;
    check_eq("reset_ready", {31'h0, ready}, 32'h1);
    check_eq("reset_done", {31'h0, done}, 32'h0);
    check_eq("reset_err", {31'h0, err}, 32'h0);
    check_eq("reset_rdata", rdata, 32'h0);
    check_eq("reset_mem_addr", mem_addr, 32'h0);
    check_eq("reset_mem_wdata", mem_wdata, 32'h0);
    check_eq("reset_mem_write", {31'h0, mem_write}, 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    preload = 1'b0; reset = 1'b0;

    run_op(1'b0, 3'b000, 8'h42, 32'h0);
    run_op(1'b0, 3'b100, 8'h42, 32'h0);
    run_op(1'b0, 3'b001, 8'h42, 32'h0);
    run_op(1'b0, 3'b101, 8'h40, 32'h0);
    run_op(1'b0, 3'b011, 8'h40, 32'h0);
    run_op(1'b1, 3'b000, 8'h41, 32'h123456EE);
    run_op(1'b0, 3'b011, 8'h40, 32'h0);
    run_op(1'b1, 3'b011, 8'h44, 32'hDEADBEEF);
    run_op(1'b0, 3'b011, 8'h44, 32'h0);
    run_op(1'b1, 3'b001, 8'h41, 32'h00005555);
    run_op(1'b0, 3'b011, 8'h40, 32'h0);
    reset_mid();

    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      ro = 3'($urandom_range(0, 7));
      ra = 8'($urandom_range(0, 255));
      run_op(rs, ro, ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
